vga_timing_rx: RTL and testbench
================================

Name: vga_timing_rx

Overview:
Receive-side counterpart of the VGA timing generator. Takes an hs/vs/de/rgb stream synchronous to `clk`. Recovers per-pixel x/y coordinates and measures line and frame geometry. Declares lock after consecutive matching frames. Used to check generator output in-system and to ingest external video into the game pipeline.

Parameters:
HS_POL, 1'b0, level of hs during the sync pulse.
VS_POL, 1'b0, level of vs during the sync pulse.
H_ACTIVE, 16'd1024, expected active pixels per line.
V_ACTIVE, 16'd768, expected active lines per frame.
LOCK_FRAMES, 2, consecutive matching frames required to lock (1..7).

Ports:
clk  in  1  pixel clock
rst_n  in  1  reset, asynchronous, active-low
hs  in  1  horizontal sync, polarity set by HS_POL
vs  in  1  vertical sync, polarity set by VS_POL
de  in  1  video valid
rgb  in  12  pixel data
px_valid  out  1  registered de
px_x  out  12  column of current valid pixel, 0-based
px_y  out  12  row of current valid pixel, 0-based
px_rgb  out  12  registered rgb
sof  out  1  one-cycle pulse with the first valid pixel of a frame
h_total_meas  out  12  clocks between hs assert edges
h_active_meas  out  12  de run length of the last line
v_total_meas  out  12  hs assert edges per frame
v_active_meas  out  12  de lines in the last frame
locked  out  1  timing matches expectation
err  out  1  one-cycle pulse on mismatch while locked

Behaviour:
- Clock and reset: one clock (`clk`); reset `rst_n` is asynchronous, active-low. On reset, all outputs are 0, all counters are 0, and the state is SEARCH.
- Input stage: hs, vs, de and rgb are registered once (d0). Sync asserted means hs==HS_POL, and likewise vs==VS_POL.
- Edge detection: assert edges and the de fall edge are decoded from d0 against d1.
- Latency: px_valid, px_x, px_y and px_rgb appear 1 clk after the matching input, and all four stay aligned.
- px_x:
  - Counts d0 de-high cycles within a line.
  - px_x = 0 on the first de cycle.
  - Clears on the de fall edge.
- px_y:
  - Increments on the de fall edge.
  - Clears on the vs assert edge.
  - Holds its value across blanking.
- sof: asserted when px_valid=1, px_x=0 and px_y=0.
- h_total counter:
  - Increments every clk.
  - On an hs assert edge: h_total_meas <= count+1, then count <= 0.
- h_active_meas: latched from the de run length on each de fall edge.
- Line counter: increments on each hs assert edge.
- On a vs assert edge:
  - v_total_meas <= line_cnt + (hs edge in same cycle ? 1 : 0).
  - line_cnt <= 0 when there is no coincident hs edge, or 1 when there is one... (resolved below).
  - Rule: an hs edge coincident with a vs edge counts into the ending frame, so after this cycle line_cnt = 0.
  - v_active_meas <= the de-line count of the ending frame.
- Saturation: all measurement counters saturate at 12'hFFF; they never wrap.
- State machine:
  - SEARCH: on a vs assert edge -> MEASURE. The partial first frame is discarded and match_cnt is set to 0.
  - MEASURE, at each vs assert edge:
    - frame_ok = (v_active_meas_next==V_ACTIVE) and every line in the frame had de run == H_ACTIVE.
    - If frame_ok: match_cnt++. When match_cnt reaches LOCK_FRAMES -> LOCKED and locked <= 1.
    - Otherwise match_cnt <= 0.
  - LOCKED: any de run != H_ACTIVE (checked at the de fall edge), or a frame with de lines != V_ACTIVE (checked at the vs edge):
    - err pulses for 1 clk;
    - locked <= 0;
    - match_cnt <= 0;
    - next state is MEASURE.
- Boundary conditions:
  - de fall edge and vs edge in the same cycle: the line counts into the ending frame.
  - de high during vs: counted normally, with no error.
  - No vs for 4095 lines: line_cnt saturates, and if LOCKED the block drops to SEARCH with an err pulse.
  - rst_n asserted mid-frame: immediate return to the reset state. Lock is regained only after the full SEARCH/MEASURE sequence.

Decomposition:
- Package vga_timing_pkg:
  - state enum {SEARCH, MEASURE, LOCKED};
  - default constants for 1024x768 timing: H_TOTAL 1344, V_TOTAL 806;
  - CNT_W = 12.
- One sub-module, vga_sync_edge: polarity normalisation plus d0/d1 registers, producing assert and fall pulses for hs, vs and de. It is instantiated once and handles all three signals.

Test Plan:
- Stream from the 1024x768 generator (H_TOTAL 1344, V_TOTAL 806), reset released at t0 -> after the first complete frame: h_total_meas=1344, h_active_meas=1024, v_total_meas=806, v_active_meas=768. locked=1 at the vs edge ending the 2nd measured frame. err never pulses.
- Same stream, inspect the first active pixel -> px_valid rises 1 clk after de with px_x=0, px_y=0, sof=1. The last pixel shows px_x=1023, px_y=767. px_rgb equals the rgb driven 1 clk earlier.
- While locked, shorten one de run on line 100 to 1000 cycles -> err pulses 1 clk at that de fall edge, h_active_meas=1000, locked=0. Relock occurs after 2 clean frames.
- HS_POL=1 and VS_POL=1 with the stream inverted -> the same measurements as the first test and locked=1.
- Pull rst_n low for 3 clks mid-frame (line 400) -> all outputs 0 immediately, with no wait for a clk edge. The next vs edge enters MEASURE, and locked=1 after 2 more frames.
- Hold vs inactive for 4100 lines while locked -> line_cnt saturates at 4095, err pulses, locked=0, state is SEARCH.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared types, constants and helpers for the VGA timing receiver
// Contents: state_t receiver state, CNT_W measurement width, 1024x768 totals,
// sat_inc saturating increment used by every measurement counter.
package vga_timing_pkg;

  localparam int CNT_W = 12;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Nominal 1024x768 totals of the matching generator.
  localparam logic [15:0] H_TOTAL = 16'd1344;
  localparam logic [15:0] V_TOTAL = 16'd806;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// rtl/vga_sync_edge.sv - polarity-normalising input register pair with edge decode
// Ports: clk, rst_n (async, active-low); hs/vs/de raw inputs;
// de_lvl = registered de (d0); hs_rise/vs_rise = sync assert edges; de_fall = de fall edge.
module vga_sync_edge #(
  parameter logic HS_POL = 1'b0,
  parameter logic VS_POL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hs,
  input  logic vs,
  input  logic de,
  output logic de_lvl,
  output logic hs_rise,
  output logic vs_rise,
  output logic de_fall
);

  // Bit order {hs_asserted, vs_asserted, de}; 1 always means active after normalisation.
  logic [2:0] d0;
  logic [2:0] d1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0 <= '0;
      d1 <= '0;
    end else begin
      d0 <= {hs == HS_POL, vs == VS_POL, de};
      d1 <= d0;
    end
  end

  assign de_lvl  = d0[0];
  assign hs_rise = d0[2] & ~d1[2];
  assign vs_rise = d0[1] & ~d1[1];
  assign de_fall = ~d0[0] & d1[0];

endmodule

// File: rtl/vga_timing_rx.sv
// rtl/vga_timing_rx.sv - VGA stream receiver: pixel coordinates, geometry measurement, lock
// Ports: clk, rst_n (async, active-low); hs/vs/de/rgb input stream;
// px_valid/px_x/px_y/px_rgb/sof pixel output 1 clk behind the input;
// h_total_meas/h_active_meas/v_total_meas/v_active_meas geometry; locked level, err pulse.
module vga_timing_rx
  import vga_timing_pkg::*;
#(
  parameter logic        HS_POL      = 1'b0,
  parameter logic        VS_POL      = 1'b0,
  parameter logic [15:0] H_ACTIVE    = 16'd1024,
  parameter logic [15:0] V_ACTIVE    = 16'd768,
  parameter int          LOCK_FRAMES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hs,
  input  logic             vs,
  input  logic             de,
  input  logic [11:0]      rgb,
  output logic             px_valid,
  output logic [CNT_W-1:0] px_x,
  output logic [CNT_W-1:0] px_y,
  output logic [11:0]      px_rgb,
  output logic             sof,
  output logic [CNT_W-1:0] h_total_meas,
  output logic [CNT_W-1:0] h_active_meas,
  output logic [CNT_W-1:0] v_total_meas,
  output logic [CNT_W-1:0] v_active_meas,
  output logic             locked,
  output logic             err
);

  localparam logic [CNT_W-1:0] H_EXP  = H_ACTIVE[CNT_W-1:0];
  localparam logic [CNT_W-1:0] V_EXP  = V_ACTIVE[CNT_W-1:0];
  localparam logic [2:0]       LOCK_N = 3'(LOCK_FRAMES);

  logic             de_lvl, hs_rise, vs_rise, de_fall;
  logic [11:0]      rgb_d0;
  logic [CNT_W-1:0] run_cnt;   // de-high cycles so far in the current run
  logic [CNT_W-1:0] y_cnt;     // de lines since the last vs edge
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] line_cnt;
  logic             line_bad;  // some line of the current frame had a wrong de run
  logic [2:0]       match_cnt;
  state_t           state;

  logic [CNT_W-1:0] v_active_next, v_total_next;
  logic [2:0]       match_inc;
  logic             run_bad, frame_ok;

  vga_sync_edge #(
    .HS_POL(HS_POL),
    .VS_POL(VS_POL)
  ) u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .hs     (hs),
    .vs     (vs),
    .de     (de),
    .de_lvl (de_lvl),
    .hs_rise(hs_rise),
    .vs_rise(vs_rise),
    .de_fall(de_fall)
  );

  // A de fall or hs edge landing on the vs edge belongs to the frame that is ending.
  assign v_active_next = de_fall ? sat_inc(y_cnt) : y_cnt;
  assign v_total_next  = hs_rise ? sat_inc(line_cnt) : line_cnt;
  assign run_bad       = de_fall && (run_cnt != H_EXP);
  assign frame_ok      = (v_active_next == V_EXP) && !line_bad && !run_bad;
  assign match_inc     = match_cnt + 3'd1;

  // run_cnt equals the 0-based column while de_lvl is high, and the run length on de_fall.
  assign px_valid = de_lvl;
  assign px_rgb   = rgb_d0;
  assign px_x     = de_lvl ? run_cnt : '0;
  assign px_y     = y_cnt;
  assign sof      = de_lvl && (run_cnt == '0) && (y_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_d0        <= '0;
      run_cnt       <= '0;
      y_cnt         <= '0;
      h_cnt         <= '0;
      line_cnt      <= '0;
      line_bad      <= 1'b0;
      h_total_meas  <= '0;
      h_active_meas <= '0;
      v_total_meas  <= '0;
      v_active_meas <= '0;
    end else begin
      rgb_d0  <= rgb;
      run_cnt <= de_lvl ? sat_inc(run_cnt) : '0;
      if (de_fall) h_active_meas <= run_cnt;

      if (hs_rise) begin
        h_total_meas <= sat_inc(h_cnt);
        h_cnt        <= '0;
      end else begin
        h_cnt <= sat_inc(h_cnt);
      end

      if (vs_rise) begin
        v_total_meas  <= v_total_next;
        v_active_meas <= v_active_next;
        line_cnt      <= '0;
        y_cnt         <= '0;
        line_bad      <= 1'b0;
      end else begin
        if (hs_rise) line_cnt <= sat_inc(line_cnt);
        if (de_fall) y_cnt <= sat_inc(y_cnt);
        if (run_bad) line_bad <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEARCH;
      match_cnt <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        SEARCH: begin
          // The frame in progress at lock-search start is partial; start counting at vs.
          if (vs_rise) begin
            state     <= MEASURE;
            match_cnt <= '0;
          end
        end
        MEASURE: begin
          if (vs_rise) begin
            if (frame_ok) begin
              match_cnt <= match_inc;
              if (match_inc == LOCK_N) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              match_cnt <= '0;
            end
          end
        end
        LOCKED: begin
          // A saturated line count means vs has vanished; restart the search entirely.
          if (line_cnt == CNT_MAX) begin
            state     <= SEARCH;
            err       <= 1'b1;
            locked    <= 1'b0;
            match_cnt <= '0;
          end else if (run_bad || (vs_rise && (v_active_next != V_EXP))) begin
            state     <= MEASURE;
            err       <= 1'b1;
            locked    <= 1'b0;
            match_cnt <= '0;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_timing_rx.sv
// tb/tb_vga_timing_rx.sv - randomized self-checking bench for vga_timing_rx on a small raster
module tb_vga_timing_rx;
  import vga_timing_pkg::*;

  // Scaled raster: 16x8 active, 24 clocks per line, 12 lines per frame.
  localparam int HA = 16, HFP = 2, HSW = 3, HT = 24;
  localparam int VA = 8, VFP = 1, VSW = 2, VT = 12;
  localparam int LOCKN = 2;
  localparam int FR = VT * HT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hs = 1'b1, vs = 1'b1, de = 1'b0;
  logic [11:0] rgb = '0;

  logic        px_valid, sof, locked, err;
  logic [11:0] px_x, px_y, px_rgb, h_total_meas, h_active_meas, v_total_meas, v_active_meas;
  logic        q_valid, q_sof, q_locked, q_err;
  logic [11:0] q_x, q_y, q_rgb, q_htot, q_hact, q_vtot, q_vact;

  int pass_cnt = 0, total = 0;

  always #5 clk = ~clk;

  vga_timing_rx #(.HS_POL(1'b0), .VS_POL(1'b0), .H_ACTIVE(16'(HA)), .V_ACTIVE(16'(VA)),
                  .LOCK_FRAMES(LOCKN)) dut (
    .clk(clk), .rst_n(rst_n), .hs(hs), .vs(vs), .de(de), .rgb(rgb),
    .px_valid(px_valid), .px_x(px_x), .px_y(px_y), .px_rgb(px_rgb), .sof(sof),
    .h_total_meas(h_total_meas), .h_active_meas(h_active_meas),
    .v_total_meas(v_total_meas), .v_active_meas(v_active_meas),
    .locked(locked), .err(err));

  vga_timing_rx #(.HS_POL(1'b1), .VS_POL(1'b1), .H_ACTIVE(16'(HA)), .V_ACTIVE(16'(VA)),
                  .LOCK_FRAMES(LOCKN)) dut_p (
    .clk(clk), .rst_n(rst_n), .hs(~hs), .vs(~vs), .de(de), .rgb(rgb),
    .px_valid(q_valid), .px_x(q_x), .px_y(q_y), .px_rgb(q_rgb), .sof(q_sof),
    .h_total_meas(q_htot), .h_active_meas(q_hact),
    .v_total_meas(q_vtot), .v_active_meas(q_vact),
    .locked(q_locked), .err(q_err));

  // Generator position and per-frame variations (cleared at each frame end).
  int g_line = 0, g_pos = 0, g_short_line = -1, g_short_len = 0;
  bit g_vs_early = 0;
  // Current and previous driven pixel, in raster coordinates.
  bit cd_de = 0, pd_de = 0;
  int cd_x = 0, cd_y = 0, pd_x = 0, pd_y = 0;
  logic [11:0] cd_rgb = '0, pd_rgb = '0;
  // Event history observed while stepping.
  bit vs_prev_drv = 0;
  int vs_edges = 0, err_cnt = 0, err_long = 0, lock_rises = 0, lock_rise_vs = -1;
  int qlock_rise_vs = -1;
  logic [11:0] err_hact = '0;
  logic err_locked = 1'b0, prev_err = 1'b0, prev_locked = 1'b0, prev_qlocked = 1'b0;

  task automatic clear_events();
    vs_edges = 0; err_cnt = 0; err_long = 0; lock_rises = 0;
    lock_rise_vs = -1; qlock_rise_vs = -1;
  endtask

  // One clock: sample DUT outputs at the negedge, then drive the next input cycle.
  task automatic clk_step(input logic h_a, input logic v_a, input logic d, input logic [11:0] c);
    @(negedge clk);
    if (err) begin
      err_cnt++;
      err_hact = h_active_meas;
      err_locked = locked;
      if (prev_err) err_long++;
    end
    prev_err = err;
    if (locked && !prev_locked) begin lock_rises++; lock_rise_vs = vs_edges; end
    prev_locked = locked;
    if (q_locked && !prev_qlocked) qlock_rise_vs = vs_edges;
    prev_qlocked = q_locked;
    if (v_a && !vs_prev_drv) vs_edges++;
    vs_prev_drv = v_a;
    hs = ~h_a; vs = ~v_a; de = d; rgb = c;
  endtask

  task automatic gen_step();
    logic h_a, v_a, d;
    logic [11:0] c;
    int len, t, vs0;
    len = (g_line == g_short_line) ? g_short_len : HA;
    d = (g_line < VA) && (g_pos < len);
    h_a = (g_pos >= HA + HFP) && (g_pos < HA + HFP + HSW);
    t = g_line * HT + g_pos;
    vs0 = g_vs_early ? ((VA - 1) * HT + HA) : ((VA + VFP) * HT + HA + HFP);
    v_a = (t >= vs0) && (t < vs0 + VSW * HT);
    c = 12'($urandom);
    pd_de = cd_de; pd_x = cd_x; pd_y = cd_y; pd_rgb = cd_rgb;
    cd_de = d; cd_x = g_pos; cd_y = g_line; cd_rgb = c;
    clk_step(h_a, v_a, d, c);
    g_pos++;
    if (g_pos == HT) begin
      g_pos = 0;
      g_line++;
      if (g_line == VT) begin
        g_line = 0; g_short_line = -1; g_vs_early = 0;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) gen_step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) clk_step(1'($urandom), 1'($urandom), 1'($urandom), 12'($urandom));
    total++; if ({px_valid, px_x, px_y, px_rgb, sof} !== '0) $display("FAIL reset_px got %h want 0", {px_valid, px_x, px_y, px_rgb, sof}); else pass_cnt++;
    total++; if ({h_total_meas, h_active_meas, v_total_meas, v_active_meas, locked, err} !== '0) $display("FAIL reset_meas got %h want 0", {h_total_meas, h_active_meas, v_total_meas, v_active_meas, locked, err}); else pass_cnt++;
    total++; if ({q_valid, q_x, q_y, q_rgb, q_sof, q_htot, q_hact, q_vtot, q_vact, q_locked, q_err} !== '0) $display("FAIL reset_pol got nonzero want 0"); else pass_cnt++;
    clk_step(1'b0, 1'b0, 1'b0, 12'h000);
    rst_n = 1'b1;
    clear_events();
  endtask

  task automatic test_lock();
    run(3 * FR);
    total++; if (lock_rises !== 1) $display("FAIL lock_rises got %0d want 1", lock_rises); else pass_cnt++;
    total++; if (lock_rise_vs !== LOCKN + 1) $display("FAIL lock_vs got %0d want %0d", lock_rise_vs, LOCKN + 1); else pass_cnt++;
    total++; if (locked !== 1'b1) $display("FAIL lock_level got %0d want 1", locked); else pass_cnt++;
    total++; if (h_total_meas !== 12'(HT)) $display("FAIL h_total got %0d want %0d", h_total_meas, HT); else pass_cnt++;
    total++; if (h_active_meas !== 12'(HA)) $display("FAIL h_active got %0d want %0d", h_active_meas, HA); else pass_cnt++;
    total++; if (v_total_meas !== 12'(VT)) $display("FAIL v_total got %0d want %0d", v_total_meas, VT); else pass_cnt++;
    total++; if (v_active_meas !== 12'(VA)) $display("FAIL v_active got %0d want %0d", v_active_meas, VA); else pass_cnt++;
    total++; if (err_cnt !== 0) $display("FAIL lock_err got %0d want 0", err_cnt); else pass_cnt++;
  endtask

  task automatic test_polarity();
    total++; if (q_locked !== 1'b1) $display("FAIL pol_locked got %0d want 1", q_locked); else pass_cnt++;
    total++; if (qlock_rise_vs !== LOCKN + 1) $display("FAIL pol_lock_vs got %0d want %0d", qlock_rise_vs, LOCKN + 1); else pass_cnt++;
    total++; if (q_htot !== 12'(HT)) $display("FAIL pol_h_total got %0d want %0d", q_htot, HT); else pass_cnt++;
    total++; if (q_hact !== 12'(HA)) $display("FAIL pol_h_active got %0d want %0d", q_hact, HA); else pass_cnt++;
    total++; if (q_vtot !== 12'(VT)) $display("FAIL pol_v_total got %0d want %0d", q_vtot, VT); else pass_cnt++;
    total++; if (q_vact !== 12'(VA)) $display("FAIL pol_v_active got %0d want %0d", q_vact, VA); else pass_cnt++;
  endtask

  task automatic test_pixels();
    for (int i = 0; i < FR; i++) begin
      gen_step();
      total++; if (px_valid !== pd_de) $display("FAIL px_valid got %0d want %0d", px_valid, pd_de); else pass_cnt++;
      total++; if (px_rgb !== pd_rgb) $display("FAIL px_rgb got %h want %h", px_rgb, pd_rgb); else pass_cnt++;
      total++; if (sof !== (pd_de && pd_x == 0 && pd_y == 0)) $display("FAIL sof got %0d at x %0d y %0d", sof, pd_x, pd_y); else pass_cnt++;
      if (pd_de) begin
        total++; if (px_x !== 12'(pd_x)) $display("FAIL px_x got %0d want %0d", px_x, pd_x); else pass_cnt++;
        total++; if (px_y !== 12'(pd_y)) $display("FAIL px_y got %0d want %0d", px_y, pd_y); else pass_cnt++;
      end
    end
  endtask

  task automatic test_coincident();
    clear_events();
    g_vs_early = 1;
    run(FR);
    total++; if (v_active_meas !== 12'(VA)) $display("FAIL coin_v_active got %0d want %0d", v_active_meas, VA); else pass_cnt++;
    total++; if (v_total_meas !== 12'd9) $display("FAIL coin_v_total got %0d want 9", v_total_meas); else pass_cnt++;
    run(FR);
    total++; if (v_total_meas !== 12'd15) $display("FAIL coin_v_total_next got %0d want 15", v_total_meas); else pass_cnt++;
    total++; if (err_cnt !== 0) $display("FAIL coin_err got %0d want 0", err_cnt); else pass_cnt++;
    total++; if (locked !== 1'b1) $display("FAIL coin_locked got %0d want 1", locked); else pass_cnt++;
  endtask

  task automatic test_short_line();
    int s, len;
    s = $urandom_range(0, VA - 1);
    len = $urandom_range(1, HA - 1);
    clear_events();
    g_short_line = s; g_short_len = len;
    run(3 * FR);
    total++; if (err_cnt !== 1) $display("FAIL short_err_cnt got %0d want 1", err_cnt); else pass_cnt++;
    total++; if (err_long !== 0) $display("FAIL short_err_width got %0d want 0", err_long); else pass_cnt++;
    total++; if (err_hact !== 12'(len)) $display("FAIL short_h_active got %0d want %0d", err_hact, len); else pass_cnt++;
    total++; if (err_locked !== 1'b0) $display("FAIL short_unlock got %0d want 0", err_locked); else pass_cnt++;
    total++; if (lock_rise_vs !== LOCKN + 1) $display("FAIL short_relock_vs got %0d want %0d", lock_rise_vs, LOCKN + 1); else pass_cnt++;
    total++; if (locked !== 1'b1) $display("FAIL short_relocked got %0d want 1", locked); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    int r, p;
    r = $urandom_range(1, VA - 1);
    p = $urandom_range(0, HT - 1);
    run(r * HT + p);
    #2 rst_n = 1'b0;
    #1;
    total++; if ({px_valid, px_x, px_y, px_rgb, sof} !== '0) $display("FAIL mid_reset_px got %h want 0", {px_valid, px_x, px_y, px_rgb, sof}); else pass_cnt++;
    total++; if ({h_total_meas, h_active_meas, v_total_meas, v_active_meas, locked, err} !== '0) $display("FAIL mid_reset_meas got %h want 0", {h_total_meas, h_active_meas, v_total_meas, v_active_meas, locked, err}); else pass_cnt++;
    run(3);
    rst_n = 1'b1;
    clear_events();
    run((VT - g_line) * HT - g_pos + 2 * FR);
    total++; if (lock_rise_vs !== LOCKN + 1) $display("FAIL mid_relock_vs got %0d want %0d", lock_rise_vs, LOCKN + 1); else pass_cnt++;
    total++; if (locked !== 1'b1) $display("FAIL mid_relocked got %0d want 1", locked); else pass_cnt++;
    total++; if (err_cnt !== 0) $display("FAIL mid_err got %0d want 0", err_cnt); else pass_cnt++;
  endtask

  task automatic test_saturation();
    clear_events();
    for (int i = 0; i < 4100; i++) begin
      clk_step(1'b1, 1'b0, 1'b0, 12'($urandom));
      for (int k = 0; k < 3; k++) clk_step(1'b0, 1'b0, 1'b0, 12'($urandom));
    end
    total++; if (err_cnt !== 1) $display("FAIL sat_err_cnt got %0d want 1", err_cnt); else pass_cnt++;
    total++; if (locked !== 1'b0) $display("FAIL sat_locked got %0d want 0", locked); else pass_cnt++;
    total++; if (dut.line_cnt !== 12'hFFF) $display("FAIL sat_line_cnt got %0d want 4095", dut.line_cnt); else pass_cnt++;
    total++; if (dut.state !== SEARCH) $display("FAIL sat_state got %0d want %0d", dut.state, SEARCH); else pass_cnt++;
    clear_events();
    run(3 * FR);
    total++; if (lock_rise_vs !== LOCKN + 1) $display("FAIL sat_relock_vs got %0d want %0d", lock_rise_vs, LOCKN + 1); else pass_cnt++;
    total++; if (locked !== 1'b1) $display("FAIL sat_relocked got %0d want 1", locked); else pass_cnt++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lock();
    test_polarity();
    test_pixels();
    test_coincident();
    test_short_line();
    test_mid_reset();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
